// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execution controller: reads two sources over one synchronous
// register-file port, drives the combinational ALU, writes back, holds C/Z.
module alu_exec_ctrl #(
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [RADDR_W-1:0] rd,
  input  logic [RADDR_W-1:0] rs_a,
  input  logic [RADDR_W-1:0] rs_b,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [RADDR_W-1:0] rf_raddr,
  input  logic [7:0]         rf_rdata,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [7:0]         rf_wdata,
  output logic [2:0]         alu_operation,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic [7:0]         alu_c,
  input  logic               alu_c_flag,
  input  logic               alu_z_flag,
  output logic               flag_c,
  output logic               flag_z
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    EXEC,
    WB
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [2:0]         op_q;
  logic [RADDR_W-1:0] rd_q;
  logic [RADDR_W-1:0] rsa_q;
  logic [RADDR_W-1:0] rsb_q;
  logic [7:0]         a_reg;
  logic [7:0]         res;
  logic               pc;
  logic               pz;
  logic               op_legal;
  logic               accept;

  always_comb begin
    op_legal = (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
    accept   = (state == IDLE) && start;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      rd_q   <= '0;
      rsa_q  <= '0;
      rsb_q  <= '0;
      a_reg  <= '0;
      res    <= '0;
      pc     <= 1'b0;
      pz     <= 1'b0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      err    <= 1'b0;
    end else begin
      err <= accept && !op_legal;
      if (accept && op_legal) begin
        op_q  <= op;
        rd_q  <= rd;
        rsa_q <= rs_a;
        rsb_q <= rs_b;
      end
      if (state == RD_B) begin
        a_reg <= rf_rdata;
      end
      if (state == EXEC) begin
        res <= alu_c;
        pc  <= alu_c_flag;
        pz  <= alu_z_flag;
      end
      if (state == WB) begin
        flag_c <= pc;
        flag_z <= pz;
      end
    end
  end

  always_comb begin
    state_next    = state;
    busy          = (state != IDLE);
    done          = 1'b0;
    rf_raddr      = '0;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    alu_operation = op_q;
    alu_a         = '0;
    alu_b         = '0;
    unique case (state)
      IDLE: begin
        if (start && op_legal) begin
          state_next = RD_A;
        end
      end
      RD_A: begin
        rf_raddr   = rsa_q;
        state_next = RD_B;
      end
      RD_B: begin
        // B is read even for unary ops so every op takes the same path
        rf_raddr   = rsb_q;
        state_next = EXEC;
      end
      EXEC: begin
        alu_a      = a_reg;
        alu_b      = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? rf_rdata : 8'h00;
        state_next = WB;
      end
      WB: begin
        rf_we      = 1'b1;
        rf_waddr   = rd_q;
        rf_wdata   = res;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomized self-checking bench: behavioural register-file/ALU environment
// plus an operation-level reference model of registers and flags.
module tb_alu_exec_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [2:0] rd = '0;
  logic [2:0] rs_a = '0;
  logic [2:0] rs_b = '0;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] rf_raddr;
  logic [7:0] rf_rdata = '0;
  logic       rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic [2:0] alu_operation;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_c;
  logic       alu_c_flag;
  logic       alu_z_flag;
  logic       flag_c;
  logic       flag_z;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] rf [8];
  logic       pre_we = 1'b0;
  logic [2:0] pre_addr = '0;
  logic [7:0] pre_data = '0;

  logic [7:0] mrf [8];
  logic       m_c = 1'b0;
  logic       m_z = 1'b0;

  alu_exec_ctrl #(.RADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rd(rd),
    .rs_a(rs_a), .rs_b(rs_b), .busy(busy), .done(done), .err(err),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_operation(alu_operation),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_c_flag(alu_c_flag),
    .alu_z_flag(alu_z_flag), .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  // Synchronous register file with a bench-side preload port
  always @(posedge clk) begin
    rf_rdata <= rf[rf_raddr];
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_addr] <= pre_data;
  end

  // Combinational ALU: 0 add, 1 sub, 2 inc, 3 dec; carry = NOT borrow on subtracts
  always_comb begin
    logic [8:0] s;
    s = 9'h000;
    case (alu_operation)
      3'd0: s = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1: s = {1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1;
      3'd2: s = {1'b0, alu_a} + 9'd1;
      3'd3: s = {1'b0, alu_a} + 9'h0FF;
      default: s = 9'h000;
    endcase
    alu_c      = s[7:0];
    alu_c_flag = s[8];
    alu_z_flag = (s[7:0] == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
    mrf[a] = d;
  endtask

  task automatic compare_rf(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), {24'h0, rf[i]}, {24'h0, mrf[i]});
  endtask

  task automatic model_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] r, output logic c);
    int x;
    case (o)
      3'd0: begin x = int'(a) + int'(b); c = (x > 255); end
      3'd1: begin x = int'(a) - int'(b); c = (a >= b); end
      3'd2: begin x = int'(a) + 1;       c = (a == 8'hFF); end
      default: begin x = int'(a) - 1;    c = (a != 8'h00); end
    endcase
    r = x[7:0];
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [2:0] d,
                        input logic [2:0] sa, input logic [2:0] sb, input bit poke_busy);
    logic [7:0] r;
    logic       c;
    int         k;
    model_op(o, mrf[sa], mrf[sb], r, c);
    @(negedge clk);
    start = 1'b1; op = o; rd = d; rs_a = sa; rs_b = sb;
    @(posedge clk);
    k = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0; op = 3'($urandom); rd = 3'($urandom);
        rs_a = 3'($urandom); rs_b = 3'($urandom);
        check({tag, "_busy"}, {31'h0, busy}, 32'd1);
      end
      if (poke_busy && n == 2) begin
        start = 1'b1; op = 3'($urandom_range(0, 3));
      end
      if (poke_busy && n == 3) start = 1'b0;
      if (done) begin k = n; break; end
    end
    start = 1'b0;
    if (k == 0) k = 9;
    check({tag, "_latency"}, k, 4);
    check({tag, "_we"}, {31'h0, rf_we}, 32'd1);
    check({tag, "_waddr"}, {29'h0, rf_waddr}, {29'h0, d});
    check({tag, "_wdata"}, {24'h0, rf_wdata}, {24'h0, r});
    check({tag, "_flags_hold"}, {30'h0, flag_c, flag_z}, {30'h0, m_c, m_z});
    mrf[d] = r; m_c = c; m_z = (r == 8'h00);
    @(negedge clk);
    check({tag, "_flags"}, {30'h0, flag_c, flag_z}, {30'h0, m_c, m_z});
    check({tag, "_idle"}, {29'h0, busy, done, rf_we}, 32'd0);
    if (poke_busy) begin
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        check({tag, "_no_second_done"}, {31'h0, done}, 32'd0);
      end
    end
  endtask

  task automatic run_illegal(input string tag, input logic [2:0] o);
    @(negedge clk);
    start = 1'b1; op = o; rd = 3'($urandom); rs_a = 3'($urandom); rs_b = 3'($urandom);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_err"}, {31'h0, err}, 32'd1);
    check({tag, "_busy"}, {30'h0, busy, rf_we}, 32'd0);
    @(negedge clk);
    check({tag, "_err_pulse"}, {30'h0, err, rf_we}, 32'd0);
    check({tag, "_flags"}, {30'h0, flag_c, flag_z}, {30'h0, m_c, m_z});
    @(negedge clk);
    check({tag, "_still_idle"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin rf[i] = 8'h00; mrf[i] = 8'h00; end
    #12;
    check("reset_out", {18'h0, busy, done, err, rf_we, rf_raddr, rf_waddr, flag_c, flag_z},
          32'd0);
    check("reset_bus", {rf_wdata, alu_operation, alu_a, alu_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    preload(3'd1, 8'h80); preload(3'd2, 8'h80);
    run_op("add_80_80", 3'd0, 3'd3, 3'd1, 3'd2, 1'b0);
    preload(3'd1, 8'h05); preload(3'd2, 8'h07);
    run_op("sub_rd_eq_a", 3'd1, 3'd1, 3'd1, 3'd2, 1'b0);
    preload(3'd4, 8'hFF); preload(3'd7, 8'h33);
    run_op("inc_ff", 3'd2, 3'd4, 3'd4, 3'd7, 1'b0);
    preload(3'd5, 8'h00);
    run_op("dec_00", 3'd3, 3'd5, 3'd5, 3'd7, 1'b0);
    preload(3'd5, 8'h07); preload(3'd6, 8'h05);
    run_op("sub_7_5", 3'd1, 3'd5, 3'd5, 3'd6, 1'b0);
    compare_rf("directed");

    run_illegal("illegal4", 3'd4);
    run_illegal("illegal7", 3'd7);
    run_op("start_while_busy", 3'd0, 3'd0, 3'd5, 3'd6, 1'b1);

    // Reset in EXEC: nothing written, flags cleared
    preload(3'd2, 8'h10); preload(3'd3, 8'h20); preload(3'd0, 8'hAA);
    @(negedge clk);
    start = 1'b1; op = 3'd0; rd = 3'd0; rs_a = 3'd2; rs_b = 3'd3;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {30'h0, busy, rf_we}, 32'd0);
    check("rst_mid_done", {30'h0, done, err}, 32'd0);
    check("rst_mid_flags", {30'h0, flag_c, flag_z}, 32'd0);
    m_c = 1'b0; m_z = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_rf("after_reset");

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 2) == 0) preload(3'($urandom), 8'($urandom));
      if ($urandom_range(0, 7) == 0)
        run_illegal("rnd_illegal", 3'($urandom_range(4, 7)));
      else
        run_op($sformatf("rnd%0d", t), 3'($urandom_range(0, 3)), 3'($urandom),
               3'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0));
    end
    compare_rf("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
